// File: rtl/ex_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Definitions shared by the EX-side hazard/forwarding logic.
//               - Forwarding-select encodings.
//               - Register index width.
//               - Stage-scoreboard entry type.
//               - A helper that decides whether a stage entry can forward
//                 to a given source index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int REG_IDX_W = 5;

  // Operand source selects driven into the EX operand muxes
  localparam logic [1:0] FWD_REG = 2'd0;  // register file value
  localparam logic [1:0] FWD_MEM = 2'd1;  // MEM-stage ALU result
  localparam logic [1:0] FWD_WB  = 2'd2;  // WB-stage write data

  // One pipeline stage's destination state as seen by the scoreboard
  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic                 wb_en;
  } sb_entry_t;

  // A stage forwards to a source only when it writes back a real register
  // (r0 is hardwired zero, so a "write" to it must never be forwarded).
  function automatic logic sb_hit(input sb_entry_t            entry,
                                  input logic [REG_IDX_W-1:0] src);
    return entry.wb_en && (entry.dest != '0) && (entry.dest == src);
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/ex_hazard_scoreboard_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Used for the stall/flush performance counters.
// Ports       : clk   - clock, updates on posedge
//               rst   - synchronous active-high reset (count -> 0)
//               inc   - increment request for this cycle
//               count - current count, W bits
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/ex_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : ex_hazard_scoreboard
// Description : EX-side hazard and forwarding controller for the 5-stage
//               core. It shadows the MEM and WB destination state, picks the
//               EX operand sources, raises the load-use stall and the
//               taken-branch flush, and counts stall/flush cycles.
// Ports       : clk, rst                 - clock / sync active-high reset
//               id_src1, id_src2         - ID-stage source indices
//               id_src2_used             - ID instruction reads src2
//               ex_dest, ex_wb_en        - ID/EX destination and WB enable
//               ex_mem_r_en              - ID/EX holds a load
//               ex_br_taken              - ID/EX branch resolved taken
//               ex_src1, ex_src2         - ID/EX source indices
//               fwd_sel_a, fwd_sel_b     - EX operand source selects
//               stall, flush             - pipeline control
//               stall_cnt, flush_cnt     - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module ex_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_src2_used,
  input  logic [4:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic             ex_br_taken,
  input  logic [4:0]       ex_src1,
  input  logic [4:0]       ex_src2,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // --------------------------------------------------------------------------
  // Shadow scoreboard of the MEM and WB stages. Bubbles enter as all-zero
  // ID/EX fields, so they naturally become non-matching entries.
  // --------------------------------------------------------------------------
  sb_entry_t r_mem;
  sb_entry_t r_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_mem.dest  <= ex_dest;
      r_mem.wb_en <= ex_wb_en;
      r_wb        <= r_mem;
    end
  end

  // --------------------------------------------------------------------------
  // Operand forwarding. MEM holds the younger producer, so it is checked
  // first and wins over WB when both write the same register.
  // --------------------------------------------------------------------------
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  always_comb begin
    w_sel_a = FWD_REG;
    if (sb_hit(r_mem, ex_src1)) begin
      w_sel_a = FWD_MEM;
    end else if (sb_hit(r_wb, ex_src1)) begin
      w_sel_a = FWD_WB;
    end
  end

  always_comb begin
    w_sel_b = FWD_REG;
    if (sb_hit(r_mem, ex_src2)) begin
      w_sel_b = FWD_MEM;
    end else if (sb_hit(r_wb, ex_src2)) begin
      w_sel_b = FWD_WB;
    end
  end

  assign fwd_sel_a = w_sel_a;
  assign fwd_sel_b = w_sel_b;

  // --------------------------------------------------------------------------
  // Load-use detection. A load's data is only available from WB, so an ID
  // instruction that consumes the load's result must wait one cycle. Once
  // the bubble is inserted the load leaves EX and the condition drops by
  // itself, which bounds every load-use stall to a single cycle.
  // --------------------------------------------------------------------------
  logic w_src1_dep;
  logic w_src2_dep;
  logic w_load_use;

  assign w_src1_dep = (ex_dest == id_src1);
  assign w_src2_dep = id_src2_used && (ex_dest == id_src2);
  assign w_load_use = ex_mem_r_en && ex_wb_en && (ex_dest != '0)
                      && (w_src1_dep || w_src2_dep);

  // A taken branch discards the ID instruction, so any stall it would have
  // needed is moot; flush takes precedence.
  logic w_flush;
  logic w_stall;

  assign w_flush = !rst && ex_br_taken;
  assign w_stall = !rst && !ex_br_taken && w_load_use;

  assign flush = w_flush;
  assign stall = w_stall;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush),
    .count (flush_cnt)
  );

endmodule : ex_hazard_scoreboard
`default_nettype wire

// File: tb/tb_ex_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_hazard_scoreboard
// Description : Self-checking bench for ex_hazard_scoreboard. Two instances
//               (16-bit and 2-bit counters) share one stimulus stream. A
//               pipeline-history model predicts every output each cycle;
//               directed literal checks pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, ex_dest, ex_src1, ex_src2;
  logic       id_src2_used, ex_wb_en, ex_mem_r_en, ex_br_taken;

  logic [1:0]  a_sel_a, a_sel_b, b_sel_a, b_sel_b;
  logic        a_stall, a_flush, b_stall, b_flush;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  ex_hazard_scoreboard #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .ex_br_taken(ex_br_taken),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .fwd_sel_a(a_sel_a), .fwd_sel_b(a_sel_b), .stall(a_stall),
    .flush(a_flush), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  ex_hazard_scoreboard #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .ex_br_taken(ex_br_taken),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .fwd_sel_a(b_sel_a), .fwd_sel_b(b_sel_b), .stall(b_stall),
    .flush(b_flush), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // --------------------------------------------------------------------------
  // Model: remembers what was in EX one and two cycles ago (the producers
  // now in MEM and WB) and plain integer event totals.
  // --------------------------------------------------------------------------
  int m_dest1 = 0, m_we1 = 0, m_dest2 = 0, m_we2 = 0;
  int m_stalls = 0, m_flushes = 0;

  function automatic int m_sel(input int src);
    if (m_we1 != 0 && m_dest1 != 0 && m_dest1 == src) return 1;
    if (m_we2 != 0 && m_dest2 != 0 && m_dest2 == src) return 2;
    return 0;
  endfunction

  function automatic int m_flush();
    return (rst == 1'b0 && ex_br_taken == 1'b1) ? 1 : 0;
  endfunction

  function automatic int m_stall();
    bit dep;
    dep = (ex_dest == id_src1) || (id_src2_used && ex_dest == id_src2);
    return (rst == 1'b0 && ex_br_taken == 1'b0 && ex_mem_r_en && ex_wb_en
            && ex_dest != 5'd0 && dep) ? 1 : 0;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_dest1 = 0; m_we1 = 0; m_dest2 = 0; m_we2 = 0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      m_stalls  = m_stalls + m_stall();
      m_flushes = m_flushes + m_flush();
      m_dest2 = m_dest1; m_we2 = m_we1;
      m_dest1 = int'(ex_dest); m_we1 = int'(ex_wb_en);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("sel_a",      int'(a_sel_a), m_sel(int'(ex_src1)));
      chk("sel_b",      int'(a_sel_b), m_sel(int'(ex_src2)));
      chk("stall",      int'(a_stall), m_stall());
      chk("flush",      int'(a_flush), m_flush());
      chk("stall_cnt",  int'(a_stall_cnt), sat(m_stalls, 65535));
      chk("flush_cnt",  int'(a_flush_cnt), sat(m_flushes, 65535));
      chk("n_sel_a",    int'(b_sel_a), m_sel(int'(ex_src1)));
      chk("n_sel_b",    int'(b_sel_b), m_sel(int'(ex_src2)));
      chk("n_stall",    int'(b_stall), m_stall());
      chk("n_flush",    int'(b_flush), m_flush());
      chk("n_stall_cnt", int'(b_stall_cnt), sat(m_stalls, 3));
      chk("n_flush_cnt", int'(b_flush_cnt), sat(m_flushes, 3));
    end
  end

  // Apply one ID/EX snapshot just after the active edge
  task automatic drive(input bit r, input int d, input bit we, input bit mr,
                       input bit br, input int s1, input int s2,
                       input int i1, input int i2, input bit i2u);
    @(posedge clk);
    #1;
    rst = r;
    ex_dest = 5'(d); ex_wb_en = we; ex_mem_r_en = mr; ex_br_taken = br;
    ex_src1 = 5'(s1); ex_src2 = 5'(s2);
    id_src1 = 5'(i1); id_src2 = 5'(i2); id_src2_used = i2u;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ex_dest = '0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; ex_br_taken = 1'b0;
    ex_src1 = '0; ex_src2 = '0; id_src1 = '0; id_src2 = '0;
    id_src2_used = 1'b0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_stall", int'(a_stall), 0);
    chk("lit_rst_cnt", int'(a_stall_cnt), 0);

    // Back-to-back ALU dependency through MEM, then through WB
    drive(0, 3, 1, 0, 0, 1, 2, 0, 0, 0);
    chk("lit_first_sel_a", int'(a_sel_a), 0);
    drive(0, 4, 1, 0, 0, 3, 0, 0, 0, 0);
    chk("lit_mem_fwd_a", int'(a_sel_a), 1);
    drive(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    chk("lit_wb_fwd_a", int'(a_sel_a), 2);

    // Both stages write r5: MEM priority on operand B
    drive(0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    chk("lit_mem_prio_b", int'(a_sel_b), 1);

    // Load-use on src1: one stall cycle, then forward from WB
    drive(0, 7, 1, 1, 0, 0, 0, 7, 0, 0);
    chk("lit_lu_stall", int'(a_stall), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    chk("lit_lu_release", int'(a_stall), 0);
    chk("lit_lu_cnt", int'(a_stall_cnt), 1);
    drive(0, 8, 1, 0, 0, 7, 0, 0, 0, 0);
    chk("lit_lu_wb_fwd", int'(a_sel_a), 2);

    // Unused src2 and r0 never cause hazards
    drive(0, 7, 1, 1, 0, 0, 0, 1, 7, 0);
    chk("lit_src2_unused", int'(a_stall), 0);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("lit_r0_nostall", int'(a_stall), 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_r0_sel", int'(a_sel_a), 0);

    // Flush beats a coincident load-use
    drive(0, 9, 1, 1, 1, 0, 0, 9, 0, 0);
    chk("lit_flush", int'(a_flush), 1);
    chk("lit_flush_nostall", int'(a_stall), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_flush_cnt", int'(a_flush_cnt), 1);
    chk("lit_stall_cnt_kept", int'(a_stall_cnt), 1);

    // Five more stall cycles: 6 total, 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) drive(0, 10, 1, 1, 0, 0, 0, 0, 10, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_sat_small", int'(b_stall_cnt), 3);
    chk("lit_sat_wide", int'(a_stall_cnt), 6);

    // Reset with a pending MEM hit discards everything
    drive(0, 11, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 12, 1, 1, 1, 11, 11, 12, 0, 0);
    chk("lit_rst_stall_forced", int'(a_stall), 0);
    chk("lit_rst_flush_forced", int'(a_flush), 0);
    drive(0, 0, 0, 0, 0, 11, 12, 0, 0, 0);
    chk("lit_post_rst_sel_a", int'(a_sel_a), 0);
    chk("lit_post_rst_sel_b", int'(a_sel_b), 0);
    chk("lit_post_rst_cnt", int'(a_stall_cnt) + int'(a_flush_cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ex_hazard_scoreboard
`default_nettype wire

// File: doc/ex_hazard_scoreboard.md
# ex_hazard_scoreboard

Hazard and forwarding controller on the EX-side of the ID/EX pipeline register in the 32-bit 5-stage core (IF, ID, EX, MEM, WB). It consumes the ID/EX register outputs and the ID-stage source indices. It keeps its own shadow copies of the MEM and WB stage destination state, and drives the EX operand-forwarding selects, the load-use stall and the taken-branch flush. Two saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- CNT_W, 16, width of stall/flush performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_src1  in  5  source register 1 of the instruction in ID.
- id_src2  in  5  source register 2 of the instruction in ID.
- id_src2_used  in  1  ID instruction reads src2 (R-type or store).
- ex_dest  in  5  ID/EX dest output.
- ex_wb_en  in  1  ID/EX WB_EN output.
- ex_mem_r_en  in  1  ID/EX MEM_R_EN output (load in EX).
- ex_br_taken  in  1  ID/EX brTaken output.
- ex_src1  in  5  ID/EX src1 output.
- ex_src2  in  5  ID/EX src2 output.
- fwd_sel_a  out  2  EX operand val1 source: 0 register file, 1 MEM-stage ALU result, 2 WB-stage write data.
- fwd_sel_b  out  2  same for val2/ST_value path.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- flush  out  1  clear IF/ID and ID/EX (bubble).
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

## Operation
- Shadow scoreboard registers: mem_dest[4:0], mem_wb_en; wb_dest[4:0], wb_wb_en.
  - Each non-reset cycle: mem_* <= ex_dest/ex_wb_en; wb_* <= mem_*.
  - Bubbles arrive as zeroed ID/EX outputs, so they need no special case.
- Register 0 never matches. A hit requires wb_en=1 and dest!=0.
- Forwarding for operand A (B identical using ex_src2):
  - MEM hit (mem_wb_en && mem_dest!=0 && mem_dest==ex_src1): sel 1.
  - Otherwise WB hit: sel 2.
  - Otherwise: sel 0.
  - MEM has priority over WB when both match (youngest producer wins).
- Load-use:
  - Condition: ex_mem_r_en && ex_wb_en && ex_dest!=0 && (ex_dest==id_src1 || (id_src2_used && ex_dest==id_src2)).
  - Result: stall=1 for exactly one cycle. The next cycle EX holds the bubble, the load is in MEM, and the condition clears. The dependent then enters EX with the load in WB, giving sel 2.
- Flush: flush = ex_br_taken.
- Simultaneous flush and load-use: flush wins; stall forced 0, because the ID instruction is being discarded.
- ID-vs-WB same-cycle read/write is the register file's write-through responsibility, not this block's.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at 2^CNT_W-1 with no wrap.

## Timing
- fwd_sel_a/b, stall, flush: combinational, same cycle as inputs (zero latency). stall and flush are forced 0 while rst=1.
- Scoreboard and counters: registered, updated at posedge. A producer in EX at cycle t is visible as a MEM hit at t+1 and as a WB hit at t+2.
- Reset values: mem_dest=0, mem_wb_en=0, wb_dest=0, wb_wb_en=0, stall_cnt=0, flush_cnt=0. Consequently fwd_sel_a=fwd_sel_b=0 and stall=flush=0.
- Reset mid-operation: all in-flight hazard state is discarded. There are no forwarding hits in the first cycle after rst deasserts.
- No stall can last more than 1 consecutive cycle for a single load.

## Structure
- Shared package pipe_pkg holds:
  - FWD_REG=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2;
  - REG_IDX_W=5;
  - the stage-scoreboard entry typedef {dest, wb_en}.
- One sub-module: sat_counter (parameter W; ports clk, rst, inc, count). It is instantiated twice.
- Match/priority logic stays inline.

## Test plan
- Back-to-back ALU dependency: EX add r3 at t, EX sub using ex_src1=3 at t+1 -> fwd_sel_a=1 at t+1; the same source at t+2 with an unrelated MEM dest -> fwd_sel_a=2.
- Both stages write r5, EX reads r5 on src2 -> fwd_sel_b=1 (MEM priority).
- Load r7 in EX (ex_mem_r_en=1), id_src1=7 -> stall=1 for 1 cycle, stall_cnt=1. Next cycle stall=0. When the dependent reaches EX, fwd_sel_a=2.
- Load r7 in EX, id_src2=7 with id_src2_used=0 -> stall=0. Writes to r0 with reads of r0 -> no stall, sel 0.
- ex_br_taken=1 coincident with a load-use condition -> flush=1, stall=0, flush_cnt=1, stall_cnt unchanged.
- CNT_W=2, stall on 5 cycles -> stall_cnt sticks at 3. Assert rst with a pending hit -> all outputs 0 next cycle.
